si5340_i2c_responder: RTL and testbench
=======================================

Name: si5340_i2c_responder

Overview:
- Synthesizable I2C target that emulates the Si5340 paged register interface on the bus side.
- Serves as the responding end of the transfers issued by the Si5340 configuration loader. Used in closed-loop simulation benches and as an on-FPGA stand-in for the device.
- Decodes START/STOP, address, register pointer and data bytes, and maintains the Si5340 page register (reg 0x01).
- Emits one write strobe per data byte and fetches read data from an external register store.

Parameters:
- DEV_ADDR, 7'h74, 7-bit I2C target address.
- SYNC_STAGES, 2, synchronizer depth on scl_pad_i/sda_pad_i (min 2).
- PAGE_REG, 8'h01, register offset of the page-select register, present on every page.

Ports:
- clk_i  in  1  system clock; must be at least 8x the SCL rate.
- arst_i  in  1  asynchronous reset, active-high.
- scl_pad_i  in  1  bus SCL. The block never drives SCL; there is no clock stretching.
- sda_pad_i  in  1  bus SDA.
- sda_pad_o  out  1  tied to 0.
- sda_padoen_o  out  1  SDA output enable, active-low: 0 = pull SDA low, 1 = release.
- wr_valid_o  out  1  one-cycle write strobe.
- wr_addr_o  out  16  {page, reg} of the write; valid with wr_valid_o.
- wr_data_o  out  8  write data; valid with wr_valid_o.
- rd_addr_o  out  16  {page, reg} of the current read pointer.
- rd_data_i  in  8  data for rd_addr_o; must be valid 1 cycle after rd_addr_o changes.
- page_o  out  8  current page register value.
- busy_o  out  1  high from START to STOP.

Behaviour:
- Reset values (arst_i high, asynchronous): sda_padoen_o=1, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, rd_addr_o=0, page_o=0, busy_o=0, FSM=IDLE, bit counter=0.
- Input conditioning:
  - SCL and SDA pass through SYNC_STAGES flops.
  - Edge detection uses the synchronized value and its one-cycle-delayed copy.
- Bus conditions:
  - START: synchronized SDA falls while synchronized SCL is high.
  - STOP: synchronized SDA rises while synchronized SCL is high.
  - STOP in any state: FSM→IDLE, SDA released, busy_o=0.
  - START in any state, including a repeated START: FSM→ADDR, bit counter cleared, busy_o=1, register pointer retained.
- Bit timing:
  - SDA is sampled on the cycle an SCL rising edge is detected; bits are MSB first.
  - sda_padoen_o changes only 1 cycle after an SCL falling edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
  - ADDR: shift 8 bits. If bits[7:1]==DEV_ADDR → ADDR_ACK (drive SDA low for the 9th clock). Otherwise → WAIT_STOP with SDA released.
    - R/W=0: next state REG.
    - R/W=1: rd_addr_o holds the pointer; the byte is loaded from rd_data_i on the ACK-clock falling edge; next state RDATA.
  - REG: shift 8 bits into the pointer → REG_ACK (ACK) → WDATA.
  - WDATA: shift 8 bits → WDATA_ACK (ACK). Write handling on the 8th rising edge:
    - Pointer == PAGE_REG: page_o ← data; no strobe.
    - Otherwise: wr_valid_o pulses for 1 cycle with wr_addr_o={page_o, pointer} and wr_data_o=data.
    - In both cases the pointer then increments; 8'hFF wraps to 8'h00 and the page is unchanged.
  - RDATA: shift the loaded byte out.
    - If the pointer == PAGE_REG, page_o is returned instead of rd_data_i.
    - After 8 bits → RDATA_ACK: SDA released, master ACK/NACK sampled, pointer incremented.
    - ACK (0): reload the byte on the falling edge → RDATA.
    - NACK (1): → WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bits until STOP or START.
- rd_addr_o always equals {page_o, pointer}.
- busy_o is set on START and cleared on STOP or reset.
- Reset mid-transfer: immediate return to reset values. A partially shifted byte is discarded and no wr_valid_o is emitted.
- Simultaneous SCL and SDA edges in the same cycle: SDA transitions are not treated as START/STOP unless synchronized SCL was high in both the current and previous cycle.

Test Plan:
- Write transfer: START, 0xE8, 0x0B, 0x5A, STOP → ACK on all 3 bytes; one wr_valid_o pulse with addr 0x000B, data 0x5A; busy_o is 1 then 0.
- Page write: START, 0xE8, 0x01, 0x02, 0x33, 0x44, STOP → page_o=0x02, no strobe for reg 0x01; strobes {0x0202, 0x33} then {0x0203, 0x44}.
- Random read: START, 0xE8, 0x10, repeated START, 0xE9; bench returns rd_data_i=0xA5 for 0x0010 and 0x3C for 0x0011; master ACKs then NACKs, then STOP → SDA bits read 0xA5, 0x3C; FSM returns to IDLE.
- Address mismatch: START, 0xD0, 0x0B, 0x11, STOP → sda_padoen_o stays 1 throughout; no wr_valid_o.
- Pointer wrap: write pointer 0xFF, data 0x01, 0x02 → strobes at 0x00FF and 0x0000 with page_o unchanged.
- Abort: assert arst_i after 4 data bits of a write; or send STOP after 5 data bits → no strobe, sda_padoen_o=1, busy_o=0; the next full transfer completes normally.

Source files
------------

// File: rtl/si5340_i2c_responder.sv
// I2C target emulating the Si5340 paged register interface.
// Writes leave as one-cycle strobes; reads pull from an external store.
module si5340_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h74,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PAGE_REG    = 8'h01
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic        wr_valid_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic [7:0]  page_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus is high, so resetting the chain to 1 avoids false edges.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl;
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_c;
  logic stop_c;

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_c  = scl & scl_d & sda_d & ~sda;
  assign stop_c   = scl & scl_d & ~sda_d & sda;

  logic [2:0] bitcnt;
  logic [6:0] shreg;
  logic [6:0] tx;
  logic [7:0] ptr;
  logic       rw;
  logic       ack_clk;
  logic       nack;
  logic       fall_d;
  logic [7:0] rx_byte;
  logic [7:0] ld_byte;
  logic       last_bit;

  assign rx_byte   = {shreg, sda};
  assign last_bit  = (bitcnt == 3'd7);
  assign ld_byte   = (ptr == PAGE_REG) ? page_o : rd_data_i;
  assign rd_addr_o = {page_o, ptr};
  assign sda_pad_o = 1'b0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= IDLE;
      bitcnt       <= 3'd0;
      shreg        <= 7'd0;
      tx           <= 7'd0;
      ptr          <= 8'd0;
      rw           <= 1'b0;
      ack_clk      <= 1'b0;
      nack         <= 1'b0;
      fall_d       <= 1'b0;
      sda_padoen_o <= 1'b1;
      wr_valid_o   <= 1'b0;
      wr_addr_o    <= 16'd0;
      wr_data_o    <= 8'd0;
      page_o       <= 8'd0;
      busy_o       <= 1'b0;
    end else begin
      wr_valid_o <= 1'b0;
      fall_d     <= scl_fall;
      if (stop_c) begin
        state        <= IDLE;
        sda_padoen_o <= 1'b1;
        busy_o       <= 1'b0;
      end else if (start_c) begin
        state        <= ADDR;
        bitcnt       <= 3'd0;
        busy_o       <= 1'b1;
        sda_padoen_o <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          ADDR, REG, WDATA: begin
            shreg   <= rx_byte[6:0];
            bitcnt  <= bitcnt + 3'd1;
            ack_clk <= 1'b0;
            if (last_bit) begin
              case (state)
                ADDR: begin
                  rw    <= sda;
                  state <= (rx_byte[7:1] == DEV_ADDR)
                         ? ADDR_ACK : WAIT_STOP;
                end
                REG: begin
                  ptr   <= rx_byte;
                  state <= REG_ACK;
                end
                default: begin
                  if (ptr == PAGE_REG) begin
                    page_o <= rx_byte;
                  end else begin
                    wr_valid_o <= 1'b1;
                    wr_addr_o  <= {page_o, ptr};
                    wr_data_o  <= rx_byte;
                  end
                  ptr   <= ptr + 8'd1;
                  state <= WDATA_ACK;
                end
              endcase
            end
          end
          RDATA: begin
            bitcnt <= bitcnt + 3'd1;
            if (last_bit) begin
              ptr     <= ptr + 8'd1;
              ack_clk <= 1'b0;
              state   <= RDATA_ACK;
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: ack_clk <= 1'b1;
          RDATA_ACK: begin
            ack_clk <= 1'b1;
            nack    <= sda;
          end
          default: ;
        endcase
      end else if (fall_d) begin
        // SDA only moves here, well clear of the next SCL rise.
        case (state)
          ADDR_ACK: begin
            if (!ack_clk) begin
              sda_padoen_o <= 1'b0;
            end else if (rw) begin
              sda_padoen_o <= ld_byte[7];
              tx           <= ld_byte[6:0];
              bitcnt       <= 3'd0;
              state        <= RDATA;
            end else begin
              sda_padoen_o <= 1'b1;
              state        <= REG;
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (!ack_clk) begin
              sda_padoen_o <= 1'b0;
            end else begin
              sda_padoen_o <= 1'b1;
              state        <= WDATA;
            end
          end
          RDATA: begin
            sda_padoen_o <= tx[6];
            tx           <= {tx[5:0], 1'b0};
          end
          RDATA_ACK: begin
            if (!ack_clk) begin
              sda_padoen_o <= 1'b1;
            end else if (nack) begin
              sda_padoen_o <= 1'b1;
              state        <= WAIT_STOP;
            end else begin
              sda_padoen_o <= ld_byte[7];
              tx           <= ld_byte[6:0];
              bitcnt       <= 3'd0;
              state        <= RDATA;
            end
          end
          default: sda_padoen_o <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_si5340_i2c_responder.sv
// Bench for si5340_i2c_responder: bit-banged I2C master,
// transaction-level register model and a write-strobe scoreboard.
module tb_si5340_i2c_responder;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_pad_o;
  logic        sda_padoen_o;
  logic        wr_valid_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic [15:0] rd_addr_o;
  logic [7:0]  rd_data_i = 8'h00;
  logic [7:0]  page_o;
  logic        busy_o;

  assign sda_bus = m_sda & (sda_padoen_o | sda_pad_o);

  always #5 clk = ~clk;

  si5340_i2c_responder dut (
    .clk_i        (clk),
    .arst_i       (arst_i),
    .scl_pad_i    (scl),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .wr_valid_o   (wr_valid_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .page_o       (page_o),
    .busy_o       (busy_o)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  rom [256];
  logic [23:0] exp_wr [$];
  logic [7:0]  m_page = 8'h00;
  logic [7:0]  m_ptr  = 8'h00;
  logic        oe_low_seen = 1'b0;

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    return rom[a[7:0]] ^ a[15:8];
  endfunction

  always @(posedge clk) rd_data_i <= rom_val(rd_addr_o);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!sda_padoen_o) oe_low_seen = 1'b1;
    if (!arst_i && wr_valid_o) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=%0h required=none",
                 {wr_addr_o, wr_data_o});
      end else begin
        chk("wr_strobe", {8'h00, wr_addr_o, wr_data_o},
            {8'h00, exp_wr.pop_front()});
      end
    end
  end

  task automatic bus_bit(input logic b, output logic s);
    #50 m_sda = b;
    #50 scl = 1'b1;
    #50 s = sda_bus;
    #50 scl = 1'b0;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      #50 m_sda = 1'b1;
      #50 scl = 1'b1;
    end
    #50 m_sda = 1'b0;
    #50 scl = 1'b0;
  endtask

  task automatic stop_cond();
    #50 m_sda = 1'b0;
    #50 scl = 1'b1;
    #50 m_sda = 1'b1;
    #50;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(mack, s);
  endtask

  task automatic post_check();
    chk("busy_idle", busy_o, 1'b0);
    chk("oe_idle", sda_padoen_o, 1'b1);
    chk("page", page_o, m_page);
    chk("rd_addr", rd_addr_o, {m_page, m_ptr});
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] bytes[$]);
    logic ack;
    logic match;
    match = (a == 7'h74);
    start_cond();
    send_byte({a, 1'b0}, ack);
    chk("addr_ack", ack, !match);
    chk("busy_mid", busy_o, 1'b1);
    foreach (bytes[i]) begin
      if (match) begin
        if (i == 0) begin
          m_ptr = bytes[i];
        end else begin
          if (m_ptr == 8'h01) m_page = bytes[i];
          else exp_wr.push_back({m_page, m_ptr, bytes[i]});
          m_ptr = m_ptr + 8'd1;
        end
      end
      send_byte(bytes[i], ack);
      chk("byte_ack", ack, !match);
    end
    stop_cond();
    post_check();
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    logic [7:0] e;
    start_cond();
    send_byte(8'hE8, ack);
    chk("rd_waddr_ack", ack, 1'b0);
    m_ptr = p;
    send_byte(p, ack);
    chk("rd_ptr_ack", ack, 1'b0);
    start_cond();
    send_byte(8'hE9, ack);
    chk("rd_raddr_ack", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      e = (m_ptr == 8'h01) ? m_page : rom_val({m_page, m_ptr});
      recv_byte(i == n - 1, d);
      chk("rd_data", d, e);
      m_ptr = m_ptr + 8'd1;
    end
    stop_cond();
    post_check();
  endtask

  task automatic abort_reset();
    logic ack;
    logic s;
    start_cond();
    send_byte(8'hE8, ack);
    send_byte(8'h20, ack);
    bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    #20 arst_i = 1'b1;
    m_page = 8'h00;
    m_ptr  = 8'h00;
    #30 m_sda = 1'b1;
    #50 scl = 1'b1;
    #50 arst_i = 1'b0;
    #50;
    post_check();
  endtask

  task automatic abort_stop();
    logic ack;
    logic s;
    logic [7:0] d;
    d = 8'hC3;
    start_cond();
    send_byte(8'hE8, ack);
    send_byte(8'h30, ack);
    m_ptr = 8'h30;
    for (int i = 7; i >= 3; i--) bus_bit(d[i], s);
    stop_cond();
    post_check();
  endtask

  task automatic mismatch(input logic [6:0] a, input logic [7:0] bytes[$]);
    oe_low_seen = 1'b0;
    do_write(a, bytes);
    chk("oe_mismatch", oe_low_seen, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL timeout actual=hang required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q [$];
    int         kind;
    int         n;
    logic [7:0] p;
    logic [6:0] a;

    foreach (rom[i]) rom[i] = 8'($urandom);
    rom[8'h10] = 8'hA5;
    rom[8'h11] = 8'h3C;

    #22;
    chk("rst_oe", sda_padoen_o, 1'b1);
    chk("rst_wr_valid", wr_valid_o, 1'b0);
    chk("rst_wr_addr", wr_addr_o, 16'h0000);
    chk("rst_wr_data", wr_data_o, 8'h00);
    chk("rst_rd_addr", rd_addr_o, 16'h0000);
    chk("rst_page", page_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    #78 arst_i = 1'b0;
    #100;

    q = {8'h0B, 8'h5A};
    do_write(7'h74, q);
    do_read(8'h10, 2);
    q = {8'h01, 8'h02, 8'h33, 8'h44};
    do_write(7'h74, q);
    q = {8'h0B, 8'h11};
    mismatch(7'h68, q);
    q = {8'hFF, 8'h01, 8'h02};
    do_write(7'h74, q);
    abort_reset();
    q = {8'h0B, 8'h5A};
    do_write(7'h74, q);
    abort_stop();
    q = {8'h40, 8'h77};
    do_write(7'h74, q);

    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      q = {};
      case (kind)
        0: begin
          p = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
          q.push_back(p);
          for (int j = 0; j < n; j++) q.push_back(8'($urandom));
          do_write(7'h74, q);
        end
        1: begin
          p = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom);
          do_read(p, n);
        end
        2: begin
          a = 7'h74 ^ 7'($urandom_range(1, 127));
          q.push_back(8'($urandom));
          q.push_back(8'($urandom));
          mismatch(a, q);
        end
        default: begin
          q.push_back(8'h01);
          for (int j = 0; j < n; j++) q.push_back(8'($urandom));
          do_write(7'h74, q);
        end
      endcase
    end

    #200;
    chk("sb_empty", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
